// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: lock-qualified reset release and tick generator behind the PLL; PLL_RESET_LOSS_COUNT_EN adds lock_loss_count.
module pll_reset_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_FILTER = 16,
  parameter int HOLD_CYCLES = 1024,
  parameter int TICK_DIV = 18
`ifdef PLL_RESET_LOSS_COUNT_EN
  , parameter int LOSS_CNT_W = 8
`endif
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       locked,
  output logic       sys_reset,
  output logic       ready,
  output logic       tick,
  output logic [1:0] state
`ifdef PLL_RESET_LOSS_COUNT_EN
  , output logic [LOSS_CNT_W-1:0] lock_loss_count
`endif
);
  localparam logic [1:0] WAIT_LOCK = 2'd0;
  localparam logic [1:0] STABILIZE = 2'd1;
  localparam logic [1:0] RUN       = 2'd2;
  localparam logic [1:0] LOST      = 2'd3;
  localparam int FW = $clog2(LOCK_FILTER) + 1;
  localparam int HW = $clog2(HOLD_CYCLES) + 1;
  localparam int TW = $clog2(TICK_DIV) + 1;
  logic [SYNC_STAGES-1:0] sync;
  logic [FW-1:0] fcnt;
  logic [HW-1:0] hcnt;
  logic [TW-1:0] tcnt;
  logic [1:0] nxt;
  logic lock_s, f_done, h_done, t_wrap;
  assign lock_s = sync[SYNC_STAGES-1];
  assign f_done = fcnt == FW'(LOCK_FILTER - 1);
  assign h_done = hcnt == HW'(HOLD_CYCLES - 1);
  assign t_wrap = tcnt == TW'(TICK_DIV - 1);
  always_comb begin
    nxt = state == WAIT_LOCK ? (lock_s && f_done ? STABILIZE : WAIT_LOCK)
        : state == STABILIZE ? (!lock_s ? WAIT_LOCK : h_done ? RUN : STABILIZE)
        : state == RUN       ? (lock_s ? RUN : LOST)
        : WAIT_LOCK;
  end
  // Outputs are decoded from nxt so they move on the same edge as state.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync      <= '0;
      fcnt      <= '0;
      hcnt      <= '0;
      tcnt      <= '0;
      state     <= WAIT_LOCK;
      sys_reset <= 1'b1;
      ready     <= 1'b0;
      tick      <= 1'b0;
    end else begin
      sync      <= {sync[SYNC_STAGES-2:0], locked};
      fcnt      <= (state == WAIT_LOCK && nxt == WAIT_LOCK && lock_s) ? fcnt + 1'b1 : '0;
      hcnt      <= (state == STABILIZE && nxt == STABILIZE) ? hcnt + 1'b1 : '0;
      tcnt      <= (state == RUN && nxt == RUN && !t_wrap) ? tcnt + 1'b1 : '0;
      state     <= nxt;
      sys_reset <= nxt != RUN;
      ready     <= nxt == RUN;
      tick      <= state == RUN && nxt == RUN && t_wrap;
    end
  end
`ifdef PLL_RESET_LOSS_COUNT_EN
  always_ff @(posedge clock) begin
    if (reset) lock_loss_count <= '0;
    else if (state == RUN && nxt == LOST && !(&lock_loss_count)) lock_loss_count <= lock_loss_count + 1'b1;
  end
`endif
endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer: directed scoreboard bench for pll_reset_sequencer (SYNC 2, FILTER 4, HOLD 8, TICK 18).
module tb_pll_reset_sequencer;
  logic clk = 1'b0, reset = 1'b1, locked = 1'b0;
  logic sys_reset, ready, tick;
  logic [1:0] state;
  int checks = 0, errors = 0;
  typedef struct {
    string tag;
    logic [1:0] st;
    logic sr, rd, tk;
  } exp_t;
  exp_t q[$];
`ifdef PLL_RESET_LOSS_COUNT_EN
  logic [1:0] lock_loss_count;
`endif
  always #5 clk = ~clk;
  pll_reset_sequencer #(
    .SYNC_STAGES(2), .LOCK_FILTER(4), .HOLD_CYCLES(8), .TICK_DIV(18)
`ifdef PLL_RESET_LOSS_COUNT_EN
    , .LOSS_CNT_W(2)
`endif
  ) dut (
    .clock(clk), .reset(reset), .locked(locked),
    .sys_reset(sys_reset), .ready(ready), .tick(tick), .state(state)
`ifdef PLL_RESET_LOSS_COUNT_EN
    , .lock_loss_count(lock_loss_count)
`endif
  );
  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask
  task automatic expect_out(input string tag, input logic [1:0] st, input logic sr, rd, tk);
    q.push_back('{tag, st, sr, rd, tk});
  endtask
  task automatic check_out();
    exp_t e;
    e = q.pop_front();
    checks++;
    assert ({state, sys_reset, ready, tick} === {e.st, e.sr, e.rd, e.tk}) else begin
      errors++;
      $error("FAIL %s: got st=%0d sr=%b rdy=%b tk=%b want st=%0d sr=%b rdy=%b tk=%b",
             e.tag, state, sys_reset, ready, tick, e.st, e.sr, e.rd, e.tk);
    end
  endtask
  task automatic step(input int n, input string tag, input logic [1:0] st, input logic sr, rd, tk);
    expect_out(tag, st, sr, rd, tk);
    adv(n);
    check_out();
  endtask
`ifdef PLL_RESET_LOSS_COUNT_EN
  task automatic check_cnt(input string tag, input logic [1:0] want);
    checks++;
    assert (lock_loss_count === want) else begin
      errors++;
      $error("FAIL %s: got cnt=%0d want cnt=%0d", tag, lock_loss_count, want);
    end
  endtask
`endif
  initial begin
    step(2, "reset", 2'd0, 1, 0, 0);
`ifdef PLL_RESET_LOSS_COUNT_EN
    check_cnt("reset_cnt", 2'd0);
`endif
    reset = 1'b0;
    locked = 1'b1;
    step(5, "lock_e4", 2'd0, 1, 0, 0);
    step(1, "lock_e5", 2'd1, 1, 0, 0);
    step(7, "lock_e12", 2'd1, 1, 0, 0);
    step(1, "lock_e13", 2'd2, 0, 1, 0);
    for (int k = 1; k <= 40; k++) step(1, "tick", 2'd2, 0, 1, k % 18 == 0);
    locked = 1'b0;
    step(1, "loss_f0", 2'd2, 0, 1, 0);
    step(1, "loss_f1", 2'd2, 0, 1, 0);
    step(1, "loss_f2", 2'd3, 1, 0, 0);
`ifdef PLL_RESET_LOSS_COUNT_EN
    check_cnt("loss_cnt", 2'd1);
`endif
    step(1, "loss_f3", 2'd0, 1, 0, 0);
    locked = 1'b1;
    adv(3);
    locked = 1'b0;
    adv(1);
    locked = 1'b1;
    step(2, "filt_e1", 2'd0, 1, 0, 0);
    step(3, "filt_e4", 2'd0, 1, 0, 0);
    step(1, "filt_e5", 2'd1, 1, 0, 0);
    step(3, "stab_mid", 2'd1, 1, 0, 0);
    locked = 1'b0;
    step(2, "stab_f1", 2'd1, 1, 0, 0);
    step(1, "stab_f2", 2'd0, 1, 0, 0);
`ifdef PLL_RESET_LOSS_COUNT_EN
    check_cnt("stab_cnt", 2'd1);
`endif
    locked = 1'b1;
    step(13, "relock_e12", 2'd1, 1, 0, 0);
    step(1, "relock_e13", 2'd2, 0, 1, 0);
    adv(5);
    reset = 1'b1;
    step(1, "mid_reset", 2'd0, 1, 0, 0);
`ifdef PLL_RESET_LOSS_COUNT_EN
    check_cnt("mid_reset_cnt", 2'd0);
`endif
    reset = 1'b0;
    step(13, "post_rst_e12", 2'd1, 1, 0, 0);
    step(1, "post_rst_e13", 2'd2, 0, 1, 0);
`ifdef PLL_RESET_LOSS_COUNT_EN
    for (int i = 0; i < 4; i++) begin
      locked = 1'b0;
      step(3, "sat_lost", 2'd3, 1, 0, 0);
      check_cnt("sat_cnt", i >= 2 ? 2'd3 : 2'(i + 1));
      adv(1);
      locked = 1'b1;
      step(14, "sat_run", 2'd2, 0, 1, 0);
    end
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
